rgb_pwm_driver: RTL and testbench
=================================

Name: rgb_pwm_driver

Overview:
Downstream stage of the AC status-light chain. Consumes the 24-bit light colour word (R in [23:16], G in [15:8], B in [7:0]) and drives three PWM outputs for the physical RGB LED. Each colour byte becomes a duty cycle. New colours are double-buffered and applied only at a PWM period boundary, so the LED never shows a torn colour mid-period.

Parameters:
PRESCALE, 4, clock cycles per PWM tick; legal range is 1 or more.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
enable  input  1  1 runs the PWM; 0 forces outputs low and holds the counters cleared
light  input  24  colour word, {R,G,B}, 8 bits per channel
load  input  1  one-cycle strobe; captures light into the pending register
pwm_r  output  1  red PWM output, registered
pwm_g  output  1  green PWM output, registered
pwm_b  output  1  blue PWM output, registered
period_start  output  1  one-cycle pulse, registered, marks the first cycle of each PWM period
update_pending  output  1  1 while a loaded colour has not yet been fully applied

Behaviour:
- Reset: synchronous, active-high, on clk rising edge.
  - Clears pre_cnt, pwm_cnt, pending, active, and all outputs to 0.
  - Reset mid-period aborts the period immediately.
- Prescaler: pre_cnt counts 0..PRESCALE-1.
  - tick = (pre_cnt == PRESCALE-1) && enable.
  - PRESCALE=1 gives a tick every cycle.
- PWM counter: pwm_cnt counts 0..254 and advances on tick, wrapping 254 -> 0.
  - Period = 255 ticks = 255*PRESCALE clocks.
- Boundary: the cycle in which tick occurs and pwm_cnt==254.
  - active <= pending, using the pending value present at the start of that cycle.
  - update_pending clears unless a load occurs in the same cycle.
  - period_start goes high in the next cycle, for exactly 1 cycle.
- Output compare: pwm_x(n+1) = (pwm_cnt(n) < active_x(n)). Latency is 1 clock.
  - Duty 0 gives always low.
  - Duty 255 gives always high.
  - High-time = duty*PRESCALE clocks per period.
- Load: on load=1, pending <= light and update_pending <= 1.
  - Multiple loads within one period: last one wins.
  - A load in the same cycle as a boundary lands in pending only and is applied at the next boundary.
- Enable low:
  - Next cycle: pre_cnt=0, pwm_cnt=0, all pwm outputs 0, period_start 0.
  - active <= pending every cycle and update_pending <= 0; loads are still accepted.
- Enable rising:
  - Counting restarts from 0 with the current active value.
  - period_start pulses in the first enabled cycle after enable was low.
- The light word is not sampled when load=0.

Optional Feature:
Macro RGB_PWM_FADE_EN.
- Defined: at each boundary, each active channel steps by 1 toward its pending channel value (+1 if below, -1 if above, unchanged if equal).
  - update_pending stays 1 until all three channels equal pending.
  - While enable is low, active still snaps directly to pending.
- Undefined: active jumps to pending in a single boundary, as described under Behaviour.

Test Plan (PRESCALE=2, period 510 clocks):
1. rst=1 for 3 cycles with load=1 and light=FFFFFF -> all outputs 0, update_pending=0 during reset and in the cycle after rst falls.
2. enable=1, load 0xFF8000, wait for period_start -> over the next 510 clocks: pwm_r high for 510, pwm_g high for 256, pwm_b high for 0.
3. Running at 0xFF8000, load 0x000000 at pwm_cnt=100 -> the rest of the current period is unchanged and update_pending=1 until the boundary; after the next period_start all outputs stay 0 and update_pending=0.
4. Load 0x101010, then 0x202020 in the same period -> the next period shows each channel high for 64 clocks; the value 0x10 never appears.
5. Drop enable at pwm_cnt=50 while running at 0x808080 -> the next cycle has all outputs 0, pwm_cnt=0, period_start=0. Re-enable after 20 cycles -> period_start pulses once, then 256-clock high pulses resume.
6. With RGB_PWM_FADE_EN defined, active=0x000000 and load 0x030000 -> over successive periods red high-times are 2, 4, 6 clocks; update_pending falls at the third boundary.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: 24-bit {R,G,B} colour word to three registered PWM outputs.
// Colours are double-buffered (pending -> active) and applied only at a
// PWM period boundary, so a period never shows a torn colour.
// Optional: define RGB_PWM_FADE_EN to step each active channel by 1 toward
// pending at every boundary instead of jumping straight to it.
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   enable         1 runs the PWM, 0 forces outputs low and clears counters
//   light[23:0]    colour word {R,G,B}
//   load           one-cycle strobe, captures light into pending
//   pwm_r/g/b      registered PWM outputs
//   period_start   registered one-cycle pulse at the start of each period
//   update_pending 1 while a loaded colour is not yet fully applied
module rgb_pwm_driver #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] light,
  input  logic        load,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        period_start,
  output logic        update_pending
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;
  logic [7:0]    r_cnt;
  logic [23:0]   r_pending;
  logic [23:0]   r_active;
  logic          r_en_d;
  logic          r_upd;

  logic          w_tick;
  logic          w_bnd;
  logic [23:0]   w_next;
  logic          w_diff;

  assign w_tick = (r_pre == PRE_LAST) && enable;
  assign w_bnd  = w_tick && (r_cnt == 8'd254);

  assign update_pending = r_upd;

`ifdef RGB_PWM_FADE_EN
  function automatic logic [7:0] step8(
    input logic [7:0] cur,
    input logic [7:0] tgt
  );
    logic [7:0] res;
    res = cur;
    if (cur < tgt)
      res = cur + 8'd1;
    else if (cur > tgt)
      res = cur - 8'd1;
    return res;
  endfunction

  always_comb begin
    w_next = {step8(r_active[23:16], r_pending[23:16]),
              step8(r_active[15:8],  r_pending[15:8]),
              step8(r_active[7:0],   r_pending[7:0])};
    // Still fading if any channel has not reached its target yet.
    w_diff = (w_next != r_pending);
  end
`else
  always_comb begin
    w_next = r_pending;
    w_diff = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre        <= '0;
      r_cnt        <= '0;
      r_pending    <= '0;
      r_active     <= '0;
      r_en_d       <= 1'b0;
      r_upd        <= 1'b0;
      pwm_r        <= 1'b0;
      pwm_g        <= 1'b0;
      pwm_b        <= 1'b0;
      period_start <= 1'b0;
    end else if (!enable) begin
      r_pre        <= '0;
      r_cnt        <= '0;
      r_active     <= r_pending;
      r_en_d       <= 1'b0;
      r_upd        <= 1'b0;
      pwm_r        <= 1'b0;
      pwm_g        <= 1'b0;
      pwm_b        <= 1'b0;
      period_start <= 1'b0;
      if (load)
        r_pending <= light;
    end else begin
      r_en_d <= 1'b1;
      r_pre  <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick)
        r_cnt <= (r_cnt == 8'd254) ? 8'd0 : r_cnt + 8'd1;
      pwm_r <= (r_cnt < r_active[23:16]);
      pwm_g <= (r_cnt < r_active[15:8]);
      pwm_b <= (r_cnt < r_active[7:0]);
      // First enabled cycle after a disabled one also starts a period.
      period_start <= w_bnd || !r_en_d;
      if (w_bnd) begin
        r_active <= w_next;
        r_upd    <= load || w_diff;
      end else if (load) begin
        r_upd <= 1'b1;
      end
      if (load)
        r_pending <= light;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: directed and random checks of rgb_pwm_driver
// against a time-in-period reference model, PRESCALE=2.
module tb_rgb_pwm_driver;

  localparam int P   = 2;
  localparam int PER = 255 * P;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] light;
  logic        load;
  logic        pwm_r;
  logic        pwm_g;
  logic        pwm_b;
  logic        period_start;
  logic        update_pending;

  int n_assert = 0;
  int n_fail   = 0;

  // model state: t = clock index within the period about to be processed
  int          t;
  logic [23:0] m_pend;
  logic [23:0] m_act;
  logic        m_en_d;
  logic        m_r, m_g, m_b, m_ps, m_upd;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(P)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .light          (light),
    .load           (load),
    .pwm_r          (pwm_r),
    .pwm_g          (pwm_g),
    .pwm_b          (pwm_b),
    .period_start   (period_start),
    .update_pending (update_pending)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int chan(input logic [23:0] w, input int k);
    return int'((w >> (8 * k)) & 24'hFF);
  endfunction

  function automatic logic [23:0] fade_step(input logic [23:0] a,
                                            input logic [23:0] p);
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      int av, pv;
      av = chan(a, k);
      pv = chan(p, k);
      if (av < pv) av = av + 1;
      else if (av > pv) av = av - 1;
      r = r | (24'(av) << (8 * k));
    end
    return r;
  endfunction

  task automatic model_step();
    logic [23:0] old_pend;
    int          duty_cnt;
    old_pend = m_pend;
    if (rst) begin
      t = 0; m_pend = '0; m_act = '0; m_en_d = 0;
      m_r = 0; m_g = 0; m_b = 0; m_ps = 0; m_upd = 0;
    end else if (!enable) begin
      t = 0; m_act = old_pend; m_en_d = 0;
      m_r = 0; m_g = 0; m_b = 0; m_ps = 0; m_upd = 0;
      if (load) m_pend = light;
    end else begin
      duty_cnt = t / P;
      m_r = duty_cnt < chan(m_act, 2);
      m_g = duty_cnt < chan(m_act, 1);
      m_b = duty_cnt < chan(m_act, 0);
      m_ps = (t == PER - 1) || !m_en_d;
      if (t == PER - 1) begin
`ifdef RGB_PWM_FADE_EN
        m_act = fade_step(m_act, old_pend);
        m_upd = load || (m_act != old_pend);
`else
        m_act = old_pend;
        m_upd = load;
`endif
      end else if (load) begin
        m_upd = 1;
      end
      if (load) m_pend = light;
      t = (t + 1) % PER;
      m_en_d = 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("pwm_r", int'(pwm_r), int'(m_r));
    chk("pwm_g", int'(pwm_g), int'(m_g));
    chk("pwm_b", int'(pwm_b), int'(m_b));
    chk("period_start", int'(period_start), int'(m_ps));
    chk("update_pending", int'(update_pending), int'(m_upd));
  endtask

  task automatic wait_ps(input string tag);
    int found;
    found = 0;
    for (int i = 0; i < 3 * PER && found == 0; i++) begin
      cyc();
      if (period_start) found = 1;
    end
    chk(tag, found, 1);
  endtask

  task automatic count_win(output int cr, output int cg,
                           output int cb, output int cps);
    cr = 0; cg = 0; cb = 0; cps = 0;
    for (int i = 0; i < PER; i++) begin
      cyc();
      cr  += int'(pwm_r);
      cg  += int'(pwm_g);
      cb  += int'(pwm_b);
      cps += int'(period_start);
    end
  endtask

  task automatic run_to_t(input int tt);
    for (int i = 0; i < 2 * PER && t != tt; i++) cyc();
    chk("reach_t", t, tt);
  endtask

  initial begin
    int hr, hg, hb, hp;
    t = 0; m_pend = '0; m_act = '0; m_en_d = 0;
    m_r = 0; m_g = 0; m_b = 0; m_ps = 0; m_upd = 0;
    rst = 1; enable = 0; load = 1; light = 24'hFFFFFF;

    // 1: reset with a load present
    #1;
    repeat (3) cyc();
    rst = 0; load = 0; light = '0;
    cyc();
    chk("upd_after_rst", int'(update_pending), 0);

    // 2: FF8000 steady
    load = 1; light = 24'hFF8000;
    cyc();
    load = 0;
    cyc();
    enable = 1;
    wait_ps("ps_t2");
    count_win(hr, hg, hb, hp);
    chk("t2_r_high", hr, 510);
    chk("t2_g_high", hg, 256);
    chk("t2_b_high", hb, 0);

    // 3: load black mid-period
    run_to_t(200);
    load = 1; light = 24'h000000;
    cyc();
    load = 0;
    chk("t3_upd_set", int'(update_pending), 1);
    wait_ps("ps_t3");
    chk("t3_upd_clr", int'(update_pending), 0);
    count_win(hr, hg, hb, hp);
    chk("t3_r_high", hr, 0);
    chk("t3_g_high", hg, 0);
    chk("t3_b_high", hb, 0);

    // 4: two loads in a period, last wins
    repeat (5) cyc();
    load = 1; light = 24'h101010;
    cyc();
    load = 0;
    repeat (7) cyc();
    load = 1; light = 24'h202020;
    cyc();
    load = 0;
    wait_ps("ps_t4");
    count_win(hr, hg, hb, hp);
    chk("t4_r_high", hr, 64);
    chk("t4_g_high", hg, 64);
    chk("t4_b_high", hb, 64);

    // 5: drop enable mid-period, then resume
    load = 1; light = 24'h808080;
    cyc();
    load = 0;
    wait_ps("ps_t5a");
    count_win(hr, hg, hb, hp);
    chk("t5_r_high", hr, 256);
    run_to_t(100);
    enable = 0;
    cyc();
    chk("t5_off_r", int'(pwm_r), 0);
    chk("t5_off_ps", int'(period_start), 0);
    repeat (19) cyc();
    enable = 1;
    wait_ps("ps_t5b");
    count_win(hr, hg, hb, hp);
    chk("t5_re_r", hr, 256);
    chk("t5_re_g", hg, 256);
    chk("t5_re_b", hb, 256);
    chk("t5_re_ps", hp, 1);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 999) == 0);
      load = ($urandom_range(0, 7) == 0);
      light = 24'($urandom);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      cyc();
    end
    rst = 0; load = 0; enable = 1;

`ifdef RGB_PWM_FADE_EN
    // 6: fade 000000 -> 030000
    rst = 1; enable = 0;
    cyc();
    rst = 0; enable = 1;
    repeat (10) cyc();
    load = 1; light = 24'h030000;
    cyc();
    load = 0;
    wait_ps("ps_t6");
    count_win(hr, hg, hb, hp);
    chk("t6_r_p1", hr, 2);
    count_win(hr, hg, hb, hp);
    chk("t6_r_p2", hr, 4);
    count_win(hr, hg, hb, hp);
    chk("t6_r_p3", hr, 6);
    chk("t6_upd", int'(update_pending), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
